// File: rtl/mem_ctrl_if.sv
// Purpose : bundles the ICache port, the load/store port and the byte-wide RAM port of mem_ctrl.
// Latency : no logic; wires only.
// Backpressure : none here; the requesters hold their level requests until served.
// Ports   : slave  = controller side (drives icache_out_en/data, lsb_done/rdata, mem_a/dout/wr)
//           master = requester/RAM side (drives icache_get_en/addr, lsb_*, mem_din)
interface mem_ctrl_if;
   logic        icache_get_en;
   logic [16:0] icache_addr;
   logic        icache_out_en;
   logic [7:0]  icache_data;

   logic        lsb_req_en;
   logic        lsb_we;
   logic [16:0] lsb_addr;
   logic [1:0]  lsb_size;
   logic [31:0] lsb_wdata;
   logic        lsb_done;
   logic [31:0] lsb_rdata;

   logic [16:0] mem_a;
   logic [7:0]  mem_dout;
   logic        mem_wr;
   logic [7:0]  mem_din;

   modport slave (
      input  icache_get_en, icache_addr, lsb_req_en, lsb_we, lsb_addr, lsb_size, lsb_wdata, mem_din,
      output icache_out_en, icache_data, lsb_done, lsb_rdata, mem_a, mem_dout, mem_wr
   );

   modport master (
      output icache_get_en, icache_addr, lsb_req_en, lsb_we, lsb_addr, lsb_size, lsb_wdata, mem_din,
      input  icache_out_en, icache_data, lsb_done, lsb_rdata, mem_a, mem_dout, mem_wr
   );
endinterface

// File: rtl/mem_ctrl.sv
// Purpose : arbitrates ICache byte fetches and LSB loads/stores onto one byte-wide RAM port.
// Latency : ICache byte returned 1 cycle after its address; load done n+2 cycles, store n+1 cycles after accept.
// Backpressure : level requests are held by the requester; an lsb request wins in IDLE, IFETCH is never preempted.
// Ports   : clk, rst (sync, active high); bus = mem_ctrl_if.slave (ICache, LSB and RAM signals).
module mem_ctrl (
   input  logic       clk,
   input  logic       rst,
   mem_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, IFETCH, DREAD, DWRITE} state_t;

   state_t      state;
   logic [2:0]  cnt;        // byte index of the access issued this cycle
   logic [2:0]  nbytes;     // 1, 2 or 4
   logic [16:0] base;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        done;
   logic        out_en;
   logic [16:0] a_hold;     // RAM address/data hold their last value while idle
   logic [7:0]  dout_hold;

   logic        lsb_accept;
   logic        ic_issue;
   logic [16:0] cur_addr;
   logic [7:0]  wbyte;
   logic [2:0]  nbytes_in;
   logic [16:0] mem_a;
   logic [7:0]  mem_dout;
   logic        mem_wr;

   // The done cycle itself is IDLE; masking the still-high request there
   // keeps the finished transaction from being accepted a second time.
   assign lsb_accept = (state == IDLE) && bus.lsb_req_en && !done;
   assign ic_issue   = bus.icache_get_en &&
                       (((state == IDLE) && !lsb_accept) || (state == IFETCH));

   // 17-bit add wraps naturally at the top of the address space.
   assign cur_addr   = base + {14'd0, cnt};

   always_comb begin
      case (bus.lsb_size)
         2'd0:    nbytes_in = 3'd1;
         2'd1:    nbytes_in = 3'd2;
         default: nbytes_in = 3'd4;   // size 3 behaves as a word
      endcase
   end

   always_comb begin
      case (cnt[1:0])
         2'd0:    wbyte = wdata[7:0];
         2'd1:    wbyte = wdata[15:8];
         2'd2:    wbyte = wdata[23:16];
         default: wbyte = wdata[31:24];
      endcase
   end

   always_comb begin
      mem_a    = a_hold;
      mem_dout = dout_hold;
      mem_wr   = 1'b0;
      if (ic_issue) begin
         mem_a = bus.icache_addr;
      end else if ((state == DREAD) && (cnt < nbytes)) begin
         mem_a = cur_addr;
      end else if (state == DWRITE) begin
         mem_a    = cur_addr;
         mem_dout = wbyte;
         mem_wr   = !rst;           // write strobe dies the moment reset rises
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= 3'd0;
         nbytes    <= 3'd0;
         base      <= 17'd0;
         wdata     <= 32'd0;
         rdata     <= 32'd0;
         done      <= 1'b0;
         out_en    <= 1'b0;
         a_hold    <= 17'd0;
         dout_hold <= 8'd0;
      end else begin
         out_en    <= ic_issue;
         done      <= 1'b0;
         a_hold    <= mem_a;
         dout_hold <= mem_dout;
         case (state)
            IDLE: begin
               if (lsb_accept) begin
                  base   <= bus.lsb_addr;
                  wdata  <= bus.lsb_wdata;
                  nbytes <= nbytes_in;
                  cnt    <= 3'd0;
                  if (bus.lsb_we) begin
                     state <= DWRITE;
                  end else begin
                     state <= DREAD;
                     rdata <= 32'd0;    // unread upper bytes read back as zero
                  end
               end else if (bus.icache_get_en) begin
                  state <= IFETCH;
               end
            end
            IFETCH: begin
               if (!bus.icache_get_en) state <= IDLE;
            end
            DREAD: begin
               // RAM data lags the address by one cycle, so at index cnt the
               // byte for address cnt-1 is on mem_din.
               case (cnt)
                  3'd1:    rdata[7:0]   <= bus.mem_din;
                  3'd2:    rdata[15:8]  <= bus.mem_din;
                  3'd3:    rdata[23:16] <= bus.mem_din;
                  3'd4:    rdata[31:24] <= bus.mem_din;
                  default: ;
               endcase
               if (cnt == nbytes) begin
                  done  <= 1'b1;
                  cnt   <= 3'd0;
                  state <= IDLE;
               end else begin
                  cnt <= cnt + 3'd1;
               end
            end
            DWRITE: begin
               if (cnt == (nbytes - 3'd1)) begin
                  done  <= 1'b1;
                  cnt   <= 3'd0;
                  state <= IDLE;
               end else begin
                  cnt <= cnt + 3'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.icache_out_en = out_en;
   assign bus.icache_data   = bus.mem_din;
   assign bus.lsb_done      = done;
   assign bus.lsb_rdata     = rdata;
   assign bus.mem_a         = mem_a;
   assign bus.mem_dout      = mem_dout;
   assign bus.mem_wr        = mem_wr;

endmodule

// File: tb/tb_mem_ctrl.sv
// Purpose : directed self-checking bench for mem_ctrl with a 1-cycle-latency byte RAM model.
// Latency : inputs driven just after the rising edge, outputs sampled on the falling edge.
// Backpressure : requests held as level signals until the expected completion cycle.
module tb_mem_ctrl;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_ctrl_if bus ();

   mem_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [7:0] ram [0:131071];

   always @(posedge clk) begin
      bus.mem_din <= ram[bus.mem_a];
      if (bus.mem_wr) ram[bus.mem_a] <= bus.mem_dout;
   end

   int checks   = 0;
   int failures = 0;

   logic [7:0] fill [4] = '{8'h13, 8'h00, 8'h00, 8'h93};

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   // Called at a falling edge with the DUT idle; the next rising edge accepts.
   task automatic lsb_op(input logic we, input logic [16:0] addr, input logic [1:0] size,
                         input logic [31:0] wd, input logic [31:0] exp_rdata);
      int n;
      int jdone;
      logic [16:0] ea;
      logic [31:0] sh;
      n     = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      jdone = we ? n + 1 : n + 2;
      bus.lsb_req_en = 1'b1;
      bus.lsb_we     = we;
      bus.lsb_addr   = addr;
      bus.lsb_size   = size;
      bus.lsb_wdata  = wd;
      for (int j = 1; j <= jdone + 1; j++) begin
         step();
         if (j == jdone + 1) bus.lsb_req_en = 1'b0;
         sample();
         chk("lsb_done", 32'(bus.lsb_done), 32'(j == jdone));
         if (j <= n) begin
            ea = addr + 17'(j - 1);
            sh = wd >> (8 * (j - 1));
            chk("lsb_mem_a", 32'(bus.mem_a), 32'(ea));
            chk("lsb_mem_wr", 32'(bus.mem_wr), 32'(we));
            if (we) chk("lsb_mem_dout", 32'(bus.mem_dout), 32'(sh[7:0]));
         end else begin
            chk("lsb_wr_quiet", 32'(bus.mem_wr), 32'd0);
         end
         if (j == jdone && !we) chk("lsb_rdata", bus.lsb_rdata, exp_rdata);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 131072; i++) ram[i] = 8'h00;
      ram[17'h100] = 8'h13; ram[17'h101] = 8'h00; ram[17'h102] = 8'h00; ram[17'h103] = 8'h93;
      ram[17'h200] = 8'h78; ram[17'h201] = 8'h56; ram[17'h202] = 8'h34; ram[17'h203] = 8'h12;
      ram[17'h301] = 8'h77;
      ram[17'h1FFFE] = 8'hAA; ram[17'h1FFFF] = 8'hBB; ram[17'h0] = 8'hCC; ram[17'h1] = 8'hDD;
      ram[17'h502] = 8'h5A; ram[17'h503] = 8'h6B;

      rst = 1'b1;
      bus.icache_get_en = 1'b0;
      bus.icache_addr   = 17'h0;
      bus.lsb_req_en    = 1'b0;
      bus.lsb_we        = 1'b0;
      bus.lsb_addr      = 17'h0;
      bus.lsb_size      = 2'd0;
      bus.lsb_wdata     = 32'h0;

      // reset state
      step(); step();
      sample();
      chk("rst_out_en", 32'(bus.icache_out_en), 32'd0);
      chk("rst_done", 32'(bus.lsb_done), 32'd0);
      chk("rst_rdata", bus.lsb_rdata, 32'd0);
      chk("rst_mem_wr", 32'(bus.mem_wr), 32'd0);
      rst = 1'b0;

      // line fill 0x100..0x103
      for (int i = 0; i <= 5; i++) begin
         step();
         bus.icache_get_en = (i < 4);
         bus.icache_addr   = 17'h100 + 17'(i);
         sample();
         if (i < 4) begin
            chk("fill_mem_a", 32'(bus.mem_a), 32'h100 + 32'(i));
            chk("fill_mem_wr", 32'(bus.mem_wr), 32'd0);
         end
         if (i >= 1 && i <= 4) begin
            chk("fill_out_en", 32'(bus.icache_out_en), 32'd1);
            chk("fill_data", 32'(bus.icache_data), 32'(fill[i - 1]));
         end else begin
            chk("fill_out_en_idle", 32'(bus.icache_out_en), 32'd0);
         end
      end

      // word load, half load, byte store
      lsb_op(1'b0, 17'h200, 2'd2, 32'h0, 32'h12345678);
      lsb_op(1'b0, 17'h200, 2'd1, 32'h0, 32'h00005678);
      lsb_op(1'b1, 17'h300, 2'd0, 32'hAABBCCDD, 32'h0);
      chk("bstore_ram300", 32'(ram[17'h300]), 32'hDD);
      chk("bstore_ram301", 32'(ram[17'h301]), 32'h77);

      // simultaneous ICache fill and word store: store first, then the fill
      for (int j = 0; j <= 9; j++) begin
         step();
         if (j == 0) begin
            bus.lsb_we    = 1'b1;
            bus.lsb_addr  = 17'h400;
            bus.lsb_size  = 2'd2;
            bus.lsb_wdata = 32'hCAFEBABE;
         end
         bus.lsb_req_en    = (j <= 5);
         bus.icache_get_en = (j <= 8);
         bus.icache_addr   = (j <= 5) ? 17'h100 : 17'h100 + 17'(j - 5);
         sample();
         if (j >= 1 && j <= 4) begin
            chk("sim_mem_wr", 32'(bus.mem_wr), 32'd1);
            chk("sim_mem_a", 32'(bus.mem_a), 32'h400 + 32'(j - 1));
            chk("sim_out_en_quiet", 32'(bus.icache_out_en), 32'd0);
         end
         if (j == 5) begin
            chk("sim_done", 32'(bus.lsb_done), 32'd1);
            chk("sim_ic_addr", 32'(bus.mem_a), 32'h100);
            chk("sim_ic_wr", 32'(bus.mem_wr), 32'd0);
         end
         if (j >= 6) begin
            chk("sim_out_en", 32'(bus.icache_out_en), 32'd1);
            chk("sim_data", 32'(bus.icache_data), 32'(fill[j - 6]));
            chk("sim_no_redo", 32'(bus.lsb_done), 32'd0);
         end
      end
      chk("sim_ram400", {ram[17'h403], ram[17'h402], ram[17'h401], ram[17'h400]}, 32'hCAFEBABE);

      // lsb request raised mid-IFETCH waits; then a wrapping word load
      for (int j = 0; j <= 4; j++) begin
         step();
         bus.icache_get_en = (j <= 2);
         bus.icache_addr   = 17'h100 + 17'(j);
         if (j == 1) begin
            bus.lsb_req_en = 1'b1;
            bus.lsb_we     = 1'b0;
            bus.lsb_addr   = 17'h1FFFE;
            bus.lsb_size   = 2'd2;
         end
         sample();
         if (j <= 2) chk("mid_ic_addr", 32'(bus.mem_a), 32'h100 + 32'(j));
         if (j >= 1 && j <= 3) chk("mid_ic_data", 32'(bus.icache_data), 32'(fill[j - 1]));
         chk("mid_no_done", 32'(bus.lsb_done), 32'd0);
         chk("mid_wr", 32'(bus.mem_wr), 32'd0);
      end
      lsb_op(1'b0, 17'h1FFFE, 2'd2, 32'h0, 32'hDDCCBBAA);

      // reset during the third byte of a word store
      bus.lsb_req_en = 1'b1;
      bus.lsb_we     = 1'b1;
      bus.lsb_addr   = 17'h500;
      bus.lsb_size   = 2'd2;
      bus.lsb_wdata  = 32'h11223344;
      for (int j = 1; j <= 3; j++) begin
         step();
         if (j == 3) rst = 1'b1;
         sample();
         chk("rstw_mem_wr", 32'(bus.mem_wr), 32'(j <= 2));
         chk("rstw_done", 32'(bus.lsb_done), 32'd0);
      end
      step();
      rst = 1'b0;
      bus.lsb_req_en = 1'b0;
      sample();
      chk("rstw_after_done", 32'(bus.lsb_done), 32'd0);
      chk("rstw_after_wr", 32'(bus.mem_wr), 32'd0);
      chk("rstw_rdata", bus.lsb_rdata, 32'd0);
      step();
      sample();
      chk("rstw_after2_done", 32'(bus.lsb_done), 32'd0);
      chk("rstw_after2_wr", 32'(bus.mem_wr), 32'd0);
      chk("rstw_ram", {ram[17'h503], ram[17'h502], ram[17'h501], ram[17'h500]}, 32'h6B5A3344);

      // controller is idle and usable again
      lsb_op(1'b0, 17'h300, 2'd0, 32'h0, 32'h000000DD);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
